// File: rtl/nn_result_classifier.sv
// Classifies NN stage results against an FP threshold and queues them for a consumer.
// A capture happens on each rising edge of nn_ready; overflowing captures are dropped but still counted.
module nn_result_classifier #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst_l,
    input  logic [exp_width+mant_width-1:0]   nn_out,
    input  logic                              nn_ready,
    input  logic [exp_width+mant_width-1:0]   thresh,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [exp_width+mant_width-1:0]   out_value,
    output logic                              out_class,
    output logic                              out_nan,
    output logic [$clog2(DEPTH):0]            fill,
    output logic [7:0]                        total,
    output logic                              overflow
);

    localparam int data_width = exp_width + mant_width;
    localparam int aw         = $clog2(DEPTH);
    localparam logic [aw:0] full_level = (aw+1)'(DEPTH);

    logic                    ready_q;
    logic                    capture;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic [aw-1:0]           wr_ptr;
    logic [aw-1:0]           rd_ptr;
    logic [data_width+1:0]   mem [DEPTH];
    logic [data_width+1:0]   head;

    logic                    a_sign;
    logic                    b_sign;
    logic [data_width-2:0]   a_mag;
    logic [data_width-2:0]   b_mag;
    logic                    a_nan;
    logic                    b_nan;
    logic                    cls;

    assign a_sign = nn_out[data_width-1];
    assign b_sign = thresh[data_width-1];
    assign a_mag  = nn_out[data_width-2:0];
    assign b_mag  = thresh[data_width-2:0];
    assign a_nan  = (&nn_out[data_width-2 -: exp_width]) & (|nn_out[mant_width-2:0]);
    assign b_nan  = (&thresh[data_width-2 -: exp_width]) & (|thresh[mant_width-2:0]);

    // Sign-magnitude ordering; both zero magnitudes compare equal regardless of sign.
    always_comb begin
        cls = 1'b0;
        if (a_nan || b_nan || ((~|a_mag) && (~|b_mag))) begin
            cls = 1'b0;
        end else if (!a_sign && b_sign) begin
            cls = 1'b1;
        end else if (a_sign && !b_sign) begin
            cls = 1'b0;
        end else if (!a_sign) begin
            cls = (a_mag > b_mag);
        end else begin
            cls = (a_mag < b_mag);
        end
    end

    assign capture   = nn_ready & ~ready_q;
    assign full      = (fill == full_level);
    assign out_valid = (fill != '0);
    assign pop       = out_valid & out_ready;
    assign push      = capture & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            ready_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            total    <= '0;
            overflow <= 1'b0;
        end else begin
            ready_q <= nn_ready;
            if (capture) total <= total + 8'd1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fill <= fill + 1'b1;
            end else if (pop && !push) begin
                fill <= fill - 1'b1;
            end
            if (capture && full && !pop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: pointers and fill decide what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {nn_out, cls, a_nan};
    end

    assign head      = mem[rd_ptr];
    assign out_value = out_valid ? head[data_width+1:2] : '0;
    assign out_class = out_valid ? head[1] : 1'b0;
    assign out_nan   = out_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_nn_result_classifier.sv
// Bench for nn_result_classifier: classifier vector table, directed FIFO corner sequences,
// and random traffic against a queue-based reference model.
module tb_nn_result_classifier;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [31:0] nn_out;
    logic        nn_ready;
    logic [31:0] thresh;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic        out_class;
    logic        out_nan;
    logic [2:0]  fill;
    logic [7:0]  total;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_result_classifier #(.exp_width(8), .mant_width(24), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l), .nn_out(nn_out), .nn_ready(nn_ready), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_class(out_class), .out_nan(out_nan), .fill(fill), .total(total),
        .overflow(overflow)
    );

    typedef struct {
        logic [31:0] val;
        logic [31:0] th;
        logic        cls;
        logic        nan;
    } vec_t;

    typedef struct packed {
        logic [31:0] v;
        logic        c;
        logic        n;
    } ent_t;

    vec_t vecs[15];
    ent_t model_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] v);
        nn_out   = v;
        nn_ready = 1'b1;
        tick();
        nn_ready = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
    endtask

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    endfunction

    // Map to a signed integer whose numeric order matches FP order (-0 and +0 both map to 0).
    function automatic longint fp_key(input logic [31:0] v);
        longint mag;
        mag = longint'({33'd0, v[30:0]});
        return v[31] ? -mag : mag;
    endfunction

    function automatic logic ref_gt(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 1'b0;
        return fp_key(a) > fp_key(b);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r = 32'h3f000000 + ($urandom_range(0, 8) - 4);
            1: r = {r[31], 8'hff, r[22:1], 1'b1};
            2: r = {r[31], 31'h7f800000};
            3: r = {r[31], 31'd0};
            4: r = {r[31], 8'h7e, r[22:0]};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] xor_vals [4];
        logic        xor_cls  [4];

        vecs[0]  = '{32'h3f7ae148, 32'h3f000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h3ca3d70a, 32'h3f000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3f000000, 32'h3f000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h7fc00000, 32'h3f000000, 1'b0, 1'b1};
        vecs[4]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[6]  = '{32'h7f800000, 32'h3f000000, 1'b1, 1'b0};
        vecs[7]  = '{32'hff800000, 32'h3f000000, 1'b0, 1'b0};
        vecs[8]  = '{32'hbf800000, 32'hc0000000, 1'b1, 1'b0};
        vecs[9]  = '{32'hc0000000, 32'hbf800000, 1'b0, 1'b0};
        vecs[10] = '{32'h3f000000, 32'h7fc00001, 1'b0, 1'b0};
        vecs[11] = '{32'h7f800001, 32'h3f000000, 1'b0, 1'b1};
        vecs[12] = '{32'h7f800000, 32'h7f800000, 1'b0, 1'b0};
        vecs[13] = '{32'h00000001, 32'h80000000, 1'b1, 1'b0};
        vecs[14] = '{32'hbf000000, 32'h3f000000, 1'b0, 1'b0};

        xor_vals = '{32'h3ca3d70a, 32'h3f7ae148, 32'h3f7ae148, 32'h3ca3d70a};
        xor_cls  = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst_l     = 1'b0;
        nn_ready  = 1'b0;
        nn_out    = 32'h3f7ae148;
        thresh    = 32'h3f000000;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", out_value, 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_total", 32'(total), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_l = 1'b1;

        // Single capture, consumer ready: visible the cycle after the capture edge.
        nn_out    = 32'h3f7ae148;
        out_ready = 1'b1;
        nn_ready  = 1'b1;
        tick();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_class", 32'(out_class), 32'd1);
        chk("basic_value", out_value, 32'h3f7ae148);
        chk("basic_total", 32'(total), 32'd1);
        nn_ready = 1'b0;
        tick();
        chk("basic_popped", 32'(fill), 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 15; i++) begin
            thresh   = vecs[i].th;
            nn_out   = vecs[i].val;
            nn_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_value", i), out_value, vecs[i].val);
            chk($sformatf("vec%0d_class", i), 32'(out_class), 32'(vecs[i].cls));
            chk($sformatf("vec%0d_nan", i), 32'(out_nan), 32'(vecs[i].nan));
            nn_ready  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_empty", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_zero", i), out_value, 32'd0);
        end

        // Four XOR results queue up, a fifth overflows, then drain in order.
        thresh = 32'h3f000000;
        do_reset();
        for (int i = 0; i < 4; i++) capture(xor_vals[i]);
        chk("xor_fill", 32'(fill), 32'd4);
        chk("xor_total", 32'(total), 32'd4);
        capture(32'h3f7ae148);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_fill", 32'(fill), 32'd4);
        chk("ovf_total", 32'(total), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_class", i), 32'(out_class), 32'(xor_cls[i]));
            chk($sformatf("drain%0d_value", i), out_value, xor_vals[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_fill", 32'(fill), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Capture and pop on the same edge while full: entry accepted.
        do_reset();
        for (int i = 0; i < 4; i++) capture(xor_vals[i]);
        nn_out    = 32'h7f800000;
        nn_ready  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        nn_ready  = 1'b0;
        chk("simul_fill", 32'(fill), 32'd4);
        chk("simul_overflow", 32'(overflow), 32'd0);
        chk("simul_head", out_value, xor_vals[1]);
        tick();
        capture(32'h3f000000);
        chk("full_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_fill", 32'(fill), 32'd3);

        // Reset mid-operation with nn_ready already high at release.
        rst_l    = 1'b0;
        nn_ready = 1'b1;
        nn_out   = 32'h3f7ae148;
        tick();
        chk("mid_rst_fill", 32'(fill), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_total", 32'(total), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        rst_l = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        nn_ready = 1'b0;
        chk("held_fill", 32'(fill), 32'd1);
        chk("held_total", 32'(total), 32'd1);
        tick();

        // 256 captures wrap the counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            capture(32'h3f7ae148);
            if (i == 254) chk("total_255", 32'(total), 32'd255);
        end
        chk("total_wrap", 32'(total), 32'd0);
        chk("wrap_fill", 32'(fill), 32'd0);
        out_ready = 1'b0;

        // Random traffic against the queue model.
        do_reset();
        model_q.delete();
        begin
            logic        prev_ready;
            logic [7:0]  m_total;
            logic        m_ovf;
            prev_ready = 1'b0;
            m_total    = 8'd0;
            m_ovf      = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic cap;
                logic pp;
                int   sz;
                ent_t e;
                nn_ready  = ($urandom_range(0, 1) == 1);
                out_ready = ($urandom_range(0, 9) < 3);
                nn_out    = rand_fp();
                thresh    = ($urandom_range(0, 1) == 1) ? 32'h3f000000 : rand_fp();
                cap = nn_ready && !prev_ready;
                sz  = model_q.size();
                pp  = (sz != 0) && out_ready;
                if (pp) void'(model_q.pop_front());
                if (cap) begin
                    m_total++;
                    e.v = nn_out;
                    e.c = ref_gt(nn_out, thresh);
                    e.n = is_nan(nn_out);
                    if (sz < DEPTH || pp) model_q.push_back(e);
                    else m_ovf = 1'b1;
                end
                prev_ready = nn_ready;
                tick();
                chk("rnd_fill", 32'(fill), 32'(model_q.size()));
                chk("rnd_total", 32'(total), 32'(m_total));
                chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
                chk("rnd_valid", 32'(out_valid), 32'(model_q.size() != 0));
                if (model_q.size() != 0) begin
                    chk("rnd_value", out_value, model_q[0].v);
                    chk("rnd_class", 32'(out_class), 32'(model_q[0].c));
                    chk("rnd_nan", 32'(out_nan), 32'(model_q[0].n));
                end else begin
                    chk("rnd_idle_value", out_value, 32'd0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
